// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// through active-high pull-low enables and reports done / error.
module ps2_host_tx #(
  parameter int CLK_FREQ          = 28_000_000,
  parameter int INHIBIT_US        = 100,
  parameter int START_TIMEOUT_US  = 15000,
  parameter int PACKET_TIMEOUT_US = 2000,
  parameter int FILTER_LEN        = 8
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error
);

  localparam int CYC_PER_US  = CLK_FREQ / 1_000_000;
  localparam int INHIBIT_CYC = INHIBIT_US * CYC_PER_US;
  localparam int REQ_CYC     = CYC_PER_US;
  localparam int START_CYC   = START_TIMEOUT_US * CYC_PER_US;
  localparam int PACKET_CYC  = PACKET_TIMEOUT_US * CYC_PER_US;
  localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int MAX_CYC     = (MAX_A > PACKET_CYC) ? MAX_A : PACKET_CYC;
  localparam int TW          = $clog2(MAX_CYC + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  localparam logic [TW-1:0] INHIBIT_LIM = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] REQ_LIM     = TW'(REQ_CYC - 1);
  localparam logic [TW-1:0] START_LIM   = TW'(START_CYC - 1);
  localparam logic [TW-1:0] PACKET_LIM  = TW'(PACKET_CYC - 1);
  localparam logic [FW-1:0] FILT_LIM    = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, dat_filt, clk_fall;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic [TW-1:0] timer, timer_n, timer_inc;
  logic [3:0]    bit_idx, bit_n;
  logic [7:0]    data_q, data_n;
  logic          parity_q, parity_n;
  logic          clk_oe_n, dat_oe_n, done_n, error_n, ready_n;

  // Bring both open-drain lines into the clk28 domain (idle level is high).
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  // Clock-line filter; also flags the 1->0 change of the filtered clock.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      clk_cnt  <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FILT_LIM) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
        clk_fall <= clk_filt;
      end else begin
        clk_cnt <= clk_cnt + FW'(1);
      end
    end
  end

  // Data-line filter, same stability rule as the clock.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      dat_filt <= 1'b1;
      dat_cnt  <= '0;
    end else begin
      if (dat_sync[1] == dat_filt) begin
        dat_cnt <= '0;
      end else if (dat_cnt == FILT_LIM) begin
        dat_filt <= dat_sync[1];
        dat_cnt  <= '0;
      end else begin
        dat_cnt <= dat_cnt + FW'(1);
      end
    end
  end

  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n  = state;
    timer_n  = timer_inc;
    bit_n    = bit_idx;
    data_n   = data_q;
    parity_n = parity_q;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    done_n   = 1'b0;
    error_n  = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        timer_n  = '0;
        if (tx_valid && tx_ready) begin
          data_n   = tx_data;
          parity_n = ~^tx_data;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        if (timer >= INHIBIT_LIM) begin
          state_n  = REQ;
          timer_n  = '0;
          dat_oe_n = 1'b1;
        end
      end
      REQ: begin
        if (timer >= REQ_LIM) begin
          state_n  = SHIFT;
          timer_n  = '0;
          clk_oe_n = 1'b0;
          bit_n    = '0;
        end
      end
      SHIFT: begin
        if (((bit_idx == 4'd0) && (timer >= START_LIM)) ||
            ((bit_idx != 4'd0) && (timer >= PACKET_LIM))) begin
          state_n  = IDLE;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          error_n  = 1'b1;
        end else if (clk_fall) begin
          bit_n = bit_idx + 4'd1;
          if (bit_idx == 4'd0) timer_n = '0;
          if (bit_idx < 4'd8) begin
            dat_oe_n = ~data_q[bit_idx[2:0]];
          end else if (bit_idx == 4'd8) begin
            dat_oe_n = ~parity_q;
          end else if (bit_idx == 4'd9) begin
            dat_oe_n = 1'b0;
          end else begin
            dat_oe_n = 1'b0;
            if (dat_filt) begin
              state_n = IDLE;
              error_n = 1'b1;
            end else begin
              state_n = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (clk_filt && dat_filt) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
      end
    endcase
    ready_n = (state_n == IDLE);
  end

  // State, datapath and output registers; reset releases both lines at once.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_idx    <= bit_n;
      data_q     <= data_n;
      parity_q   <= parity_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      tx_ready   <= ready_n;
      busy       <= ~ready_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

  assign rx_inhibit = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 2800;
  localparam int REQ_CYC     = 28;
  localparam int START_CYC   = 8400;
  localparam int FILTER_LEN  = 8;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int donePulses = 0;
  int errPulses  = 0;
  int bothPulses = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.START_TIMEOUT_US(300)) dut (
    .clk28(clk28), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .rx_inhibit(rx_inhibit), .done(done), .error(error)
  );

  always #18 clk28 = ~clk28;

  always @(negedge clk28) begin
    if (done) donePulses++;
    if (error) errPulses++;
    if (done && error) bothPulses++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int i;
    i = 0;
    while (!tx_ready && i < 1000) begin step(); i++; end
    checkOutput("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic waitRelease();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      step();
      if (!ps2_clk_oe && busy) ok = 1'b1;
    end
    checkOutput("release_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic runDevice(input int half, input bit nack, input bit glitch, output logic [9:0] bits);
    bits = '0;
    repeat (200) step();
    for (int n = 0; n < 11; n++) begin
      if (n == 10) begin
        dev_dat = nack;
        repeat (half / 2) step();
      end
      dev_clk = 1'b0;
      repeat (half / 2) step();
      if (n < 10) bits[n] = ps2_dat_oe;
      if (glitch && n == 4) begin dev_clk = 1'b1; repeat (3) step(); dev_clk = 1'b0; end
      repeat (half - half / 2) step();
      dev_clk = 1'b1;
      repeat (half / 2) step();
      if (glitch && n == 4) begin dev_clk = 1'b0; repeat (3) step(); dev_clk = 1'b1; end
      repeat (half - half / 2) step();
    end
    dev_dat = 1'b1;
  endtask

  task automatic waitDone(input string tag);
    int i;
    i = 0;
    while (!done && !error && i < 3000) begin step(); i++; end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_no_error"}, {31'd0, error}, 32'd0);
    checkOutput({tag, "_ready_at_done"}, {31'd0, tx_ready}, 32'd1);
    step();
    checkOutput({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy_cleared"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [9:0] bits;
    logic [9:0] expA;
    int cnt, cnt2, d0, e0;

    $display("[TB] starting");
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done_error", {30'd0, done, error}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    // 0xED at 80 us device clock period
    applyStimulus(8'hED);
    checkOutput("ed_accept_ready", {31'd0, tx_ready}, 32'd0);
    checkOutput("ed_accept_busy", {31'd0, busy}, 32'd1);
    checkOutput("ed_accept_inhibit", {31'd0, rx_inhibit}, 32'd1);
    checkOutput("ed_accept_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    cnt = 0;
    while (ps2_clk_oe && !ps2_dat_oe && cnt < 6000) begin cnt++; step(); end
    checkOutput("ed_inhibit_cycles", cnt, INHIBIT_CYC);
    cnt2 = 0;
    while (ps2_clk_oe && ps2_dat_oe && cnt2 < 200) begin cnt2++; step(); end
    checkOutput("ed_req_cycles", cnt2, REQ_CYC);
    checkOutput("ed_release_start_bit", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    d0 = donePulses;
    e0 = errPulses;
    runDevice(1120, 1'b0, 1'b0, bits);
    expA = 10'h012;
    for (int n = 0; n < 10; n++)
      checkOutput($sformatf("ed_bit%0d", n), {31'd0, bits[n]}, {31'd0, expA[n]});
    waitDone("ed");
    checkOutput("ed_done_count", donePulses - d0, 1);
    checkOutput("ed_error_count", errPulses - e0, 0);

    // 0x01: parity bit forces data low after edge 8
    applyStimulus(8'h01);
    waitRelease();
    runDevice(140, 1'b0, 1'b0, bits);
    checkOutput("x01_parity_oe", {31'd0, bits[8]}, 32'd1);
    checkOutput("x01_bits", {22'd0, bits}, 32'h1FE);
    waitDone("x01");

    // device never clocks: start timeout
    applyStimulus(8'h5A);
    waitRelease();
    cnt = 0;
    while (!error && cnt < START_CYC + 200) begin step(); cnt++; end
    checkOutput("timeout_error", {31'd0, error}, 32'd1);
    checkCount++;
    assert (cnt >= START_CYC - FILTER_LEN - 4 && cnt <= START_CYC + FILTER_LEN + 4) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL timeout_cycles: observed=%0d expected=%0d", cnt, START_CYC);
    end
    checkOutput("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput("timeout_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("timeout_no_done", {31'd0, done}, 32'd0);
    step();

    // NACK: data left high at edge 10
    d0 = donePulses;
    e0 = errPulses;
    applyStimulus(8'hF4);
    waitRelease();
    runDevice(140, 1'b1, 1'b0, bits);
    repeat (50) step();
    checkOutput("nack_error_count", errPulses - e0, 1);
    checkOutput("nack_done_count", donePulses - d0, 0);
    checkOutput("nack_ready", {31'd0, tx_ready}, 32'd1);

    // short clock glitches mid-byte
    applyStimulus(8'hA5);
    waitRelease();
    runDevice(140, 1'b0, 1'b1, bits);
    checkOutput("glitch_bits", {22'd0, bits}, 32'h05A);
    waitDone("glitch");

    // reset during SHIFT
    applyStimulus(8'h3C);
    waitRelease();
    repeat (200) step();
    dev_clk = 1'b0;
    repeat (70) step();
    checkOutput("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, tx_ready}, 32'd1);
    dev_clk = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checkOutput("after_rst_ready", {31'd0, tx_ready}, 32'd1);
    applyStimulus(8'h3C);
    waitRelease();
    runDevice(140, 1'b0, 1'b0, bits);
    checkOutput("after_rst_bits", {22'd0, bits}, 32'h0C3);
    waitDone("after_rst");

    checkOutput("never_done_and_error", bothPulses, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
